// File: rtl/mdu_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdu_seq_pkg : shared RV32M opcode, state and special-result definitions     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package mdu_seq_pkg;

    localparam logic [2:0] MDU_OP_MUL    = 3'b000;
    localparam logic [2:0] MDU_OP_MULH   = 3'b001;
    localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
    localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
    localparam logic [2:0] MDU_OP_DIV    = 3'b100;
    localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
    localparam logic [2:0] MDU_OP_REM    = 3'b110;
    localparam logic [2:0] MDU_OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_CALC = 2'd1,
        MDU_ST_DONE = 2'd2
    } mdu_state_t;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_Q  = 32'h8000_0000;

    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == MDU_OP_MULH) || (op == MDU_OP_DIV) || (op == MDU_OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdu_div_core : restoring divider step register, one quotient bit per step   |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module mdu_div_core
    import mdu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quo_nxt_o,
    output logic [XLEN-1:0] rem_nxt_o
);

    logic [2*XLEN-1:0] r_rq;
    logic [XLEN-1:0]   r_divisor;
    logic [XLEN:0]     w_top;
    logic [XLEN-1:0]   w_diff;
    logic              w_fit;

    // Shifted partial remainder needs one extra bit when the divisor exceeds 2^(XLEN-1).
    assign w_top     = r_rq[2*XLEN-1:XLEN-1];
    assign w_fit     = (w_top >= {1'b0, r_divisor});
    assign w_diff    = w_top[XLEN-1:0] - r_divisor;
    assign rem_nxt_o = w_fit ? w_diff : w_top[XLEN-1:0];
    assign quo_nxt_o = {r_rq[XLEN-2:0], w_fit};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rq      <= '0;
            r_divisor <= '0;
        end else if (start_i) begin
            r_rq      <= {{XLEN{1'b0}}, dividend_i};
            r_divisor <= divisor_i;
        end else if (step_i) begin
            r_rq      <= {rem_nxt_o, quo_nxt_o};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdu_seq : multi-cycle RV32M sequencer (MUL*/DIV*/REM*) with stall/done      |
// |           MDU_FAST_MUL_EN selects a single-cycle multiplier               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    mdu_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_neg_q, r_neg_r;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_result;

    logic              w_accept, w_last, w_special;
    logic              w_sa, w_sb, w_div_zero, w_div_ovf;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special_res, w_calc_res;
    logic [XLEN:0]     w_acc_sum;
    logic [2*XLEN-1:0] w_acc_nxt, w_prod;
    logic [XLEN-1:0]   w_quo_nxt, w_rem_nxt, w_quo_s, w_rem_s;

    assign w_accept   = (r_state == MDU_ST_IDLE) && valid_i && !flush_i;
    assign w_last     = (r_state == MDU_ST_CALC) && (r_cnt == '0);

    assign w_sa       = op_signed_a(op_i) & a_i[XLEN-1];
    assign w_sb       = op_signed_b(op_i) & b_i[XLEN-1];
    assign w_a_mag    = w_sa ? -a_i : a_i;
    assign w_b_mag    = w_sb ? -b_i : b_i;

    assign w_div_zero = op_i[2] && (b_i == '0);
    assign w_div_ovf  = ((op_i == MDU_OP_DIV) || (op_i == MDU_OP_REM)) &&
                        (a_i == DIV_OVF_Q) && (b_i == '1);

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fa, w_fb, w_fast;
    assign w_fa      = {{XLEN{w_sa}}, a_i};
    assign w_fb      = {{XLEN{w_sb}}, b_i};
    assign w_fast    = w_fa * w_fb;
    assign w_special = w_div_zero || w_div_ovf || !op_i[2];
`else
    assign w_special = w_div_zero || w_div_ovf;
`endif

    // REM/REMU have op[1] set, DIV/DIVU do not.
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = op_i[1] ? a_i : DIV_ZERO_Q;
        end else if (w_div_ovf) begin
            w_special_res = op_i[1] ? '0 : DIV_OVF_Q;
        end
`ifdef MDU_FAST_MUL_EN
        else if (!op_i[2]) begin
            w_special_res = (op_i == MDU_OP_MUL) ? w_fast[XLEN-1:0] : w_fast[2*XLEN-1:XLEN];
        end
`endif
    end

    // Shift-add multiplier: the multiplier sits in the low half and drains out as the product fills in.
    assign w_acc_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_nxt = {w_acc_sum, r_acc[XLEN-1:1]};
    assign w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    assign w_quo_s   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_s   = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    always_comb begin
        w_calc_res = w_rem_s;
        case (r_op)
            MDU_OP_MUL:                             w_calc_res = w_prod[XLEN-1:0];
            MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_MULHU: w_calc_res = w_prod[2*XLEN-1:XLEN];
            MDU_OP_DIV, MDU_OP_DIVU:                w_calc_res = w_quo_s;
            default:                                w_calc_res = w_rem_s;
        endcase
    end

    mdu_div_core #(.XLEN(XLEN)) u_div_core (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (w_accept),
        .step_i     ((r_state == MDU_ST_CALC) && r_op[2] && !flush_i),
        .dividend_i (w_a_mag),
        .divisor_i  (w_b_mag),
        .quo_nxt_o  (w_quo_nxt),
        .rem_nxt_o  (w_rem_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= MDU_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MDU_ST_IDLE: if (w_accept) w_state_nxt = w_special ? MDU_ST_DONE : MDU_ST_CALC;
            MDU_ST_CALC: if (w_last)   w_state_nxt = MDU_ST_DONE;
            MDU_ST_DONE: w_state_nxt = MDU_ST_IDLE;
            default:     w_state_nxt = MDU_ST_IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = MDU_ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt    <= '1;
            r_op     <= op_i;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_acc    <= {{XLEN{1'b0}}, w_b_mag};
            r_mcand  <= w_a_mag;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if ((r_state == MDU_ST_CALC) && !flush_i) begin
            r_cnt <= r_cnt - 1'b1;
            if (!r_op[2]) begin
                r_acc <= w_acc_nxt;
            end
            if (w_last) begin
                r_result <= w_calc_res;
            end
        end
    end

    assign done_o   = (r_state == MDU_ST_DONE);
    assign busy_o   = (r_state != MDU_ST_IDLE);
    assign stall_o  = valid_i && !done_o && !flush_i;
    assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mdu_seq : directed + randomized self-checking bench for mdu_seq          |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_mdu_seq;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    mdu_seq dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .valid_i  (valid_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference result from RV32M semantics using 64-bit integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation; returns at the done cycle with valid_i still high.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat, stalls, want;
        bit seen;
        want = exp_lat(op, a, b);
        @(posedge clk_i); #1;
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
        lat = -1; stalls = 0; seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (k == 0) check_val({tag, "_busy_at_accept"}, 64'(busy_o), 64'd0);
            if (done_o) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
            if (stall_o) stalls++;
        end
        check_val({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check_val({tag, "_latency"}, 64'(lat), 64'(want));
            check_val({tag, "_stall_cycles"}, 64'(stalls), 64'(want));
            check_val({tag, "_result"}, 64'(result_o), 64'(exp));
            check_val({tag, "_stall_at_done"}, 64'(stall_o), 64'd0);
        end
    endtask

    task automatic go_idle(input string tag);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(negedge clk_i);
        check_val({tag, "_done_one_cycle"}, 64'(done_o), 64'd0);
        check_val({tag, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    task automatic count_no_done(input string tag);
        int n;
        n = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o) n++;
        end
        check_val({tag, "_no_done"}, 64'(n), 64'd0);
    endtask

    initial begin
        rst_n_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
        op_i = 3'd0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_val("rst_done",   64'(done_o),   64'd0);
        check_val("rst_busy",   64'(busy_o),   64'd0);
        check_val("rst_result", 64'(result_o), 64'd0);
        check_val("rst_stall",  64'(stall_o),  64'd0);
        rst_n_i = 1'b1;

        run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD); go_idle("div_m7_2");
        run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF); go_idle("rem_m7_2");
        run_op("divu_z",    3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF); go_idle("divu_z");
        run_op("remu_z",    3'd7, 32'h1234_5678, 32'd0, 32'h1234_5678); go_idle("remu_z");
        run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); go_idle("div_ovf");
        run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0); go_idle("rem_ovf");
        run_op("mulh",      3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); go_idle("mulh");
        run_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); go_idle("mulhsu");
        run_op("mulhu",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); go_idle("mulhu");

        run_op("b2b_mul",   3'd0, 32'd3,   32'd5, 32'd15);
        run_op("b2b_divu",  3'd5, 32'd100, 32'd7, 32'd14);
        go_idle("b2b");

        // Flush during CALC cycle 10 of a DIV.
        @(posedge clk_i); #1;
        valid_i = 1'b1; op_i = 3'd4; a_i = 32'd1000; b_i = 32'd7;
        repeat (10) @(negedge clk_i);
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        @(negedge clk_i);
        check_val("flush_stall", 64'(stall_o), 64'd0);
        check_val("flush_busy_calc", 64'(busy_o), 64'd1);
        @(posedge clk_i); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        @(negedge clk_i);
        check_val("flush_idle", 64'(busy_o), 64'd0);
        check_val("flush_done", 64'(done_o), 64'd0);
        count_no_done("flush");
        run_op("remu_10_3", 3'd7, 32'd10, 32'd3, 32'd1); go_idle("remu_10_3");

        // Asynchronous reset in the middle of CALC.
        @(posedge clk_i); #1;
        valid_i = 1'b1; op_i = 3'd4; a_i = 32'hFFFF_FF9C; b_i = 32'd9;
        repeat (6) @(negedge clk_i);
        #2;
        rst_n_i = 1'b0; valid_i = 1'b0;
        #1;
        check_val("arst_done",   64'(done_o),   64'd0);
        check_val("arst_busy",   64'(busy_o),   64'd0);
        check_val("arst_result", 64'(result_o), 64'd0);
        check_val("arst_stall",  64'(stall_o),  64'd0);
        @(posedge clk_i);
        @(posedge clk_i); #3;
        rst_n_i = 1'b1;
        count_no_done("arst");
        run_op("post_rst", 3'd4, 32'hFFFF_FF9C, 32'd9, 32'hFFFF_FFF5); go_idle("post_rst");

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            rop = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, ref_result(rop, ra, rb));
            if ($urandom_range(0, 1) == 1) go_idle($sformatf("rnd%0d", i));
        end
        go_idle("end");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
